intr_ctrl: RTL
==============

# intr_ctrl

Interrupt source aggregator upstream of the machine-mode CSR/privilege unit. Latches single-cycle external `irq` pulses into sticky pending bits, runs the 64-bit `mtime`/`mtimecmp` machine timer, and presents one interrupt at a time to the privilege unit over the `eip`/`eip_istimer`/`eip_reply` handshake. Software accesses it through a small memory-mapped register file on the system bus.

## Interface
- `N_IRQ`, default 4: number of external interrupt lines, 1..16.
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clocks, ≥1.
- `HOLDOFF`, default 2: cycles `eip` is forced low after each reply, ≥2.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset; asserted when 0.
- `a` in 4: word register index.
- `d` in 32: write data.
- `we` in 1: write strobe, one write per cycle.
- `spo` out 32: combinational read data for `a`.
- `irq` in N_IRQ: external interrupt pulses, one cycle each.
- `eip` out 1: interrupt presented to the privilege unit.
- `eip_istimer` out 1: the presented interrupt is the timer.
- `eip_reply` in 1: acknowledge pulse from the privilege unit.

## Operation
- Register map, indexed by `a`:
  - 0: `mtime[31:0]`; 1: `mtime[63:32]`.
  - 2: `mtimecmp[31:0]`; 3: `mtimecmp[63:32]`.
  - 4: `pending`. Read gives the bits. Writing 1 to a bit clears it.
  - 5: `enable`, read/write.
  - 6: `claim`, read-only: `{valid, 26'b0, id[4:0]}` of the last serviced source, where id 16 means the timer.
  - Other indices read 0. Writes to them are ignored.
- Reset values: `mtime`=0, `mtimecmp`=all ones, `pending`=0, `enable`=0, `claim`=0, prescaler=0, `eip`=0, `eip_istimer`=0, state=IDLE.
- Timer:
  - `mtime` is free-running and carries from the low word into the high word.
  - `timer_pend` = unsigned `mtime >= mtimecmp`, compared on registered values.
  - `timer_pend` is a level, never latched. Software clears it by rewriting `mtimecmp`.
- An `irq[i]` pulse sets `pending[i]`.
- Arbitration happens in IDLE only. Priority order:
  1. Lowest-index `pending & enable` bit.
  2. Otherwise `timer_pend`.
- The winner is latched as `sel_id`.
- FSM:
  - IDLE: if any source is eligible, latch `sel_id`, set `eip`=1 and set `eip_istimer`=(winner is timer), go to ASSERT.
  - ASSERT: `eip` and `eip_istimer` stay stable until `eip_reply`=1. On reply:
    - `eip`=0.
    - If the winner is external, clear `pending[sel_id]`.
    - `claim`={1,`sel_id`}.
    - Load the holdoff counter with `HOLDOFF`-1 and go to HOLDOFF.
  - HOLDOFF: count down to 0, then go to IDLE. `eip` stays 0. This lets the privilege unit's registered sampling settle.
- Boundary rules:
  - `irq[i]` in the same cycle as a clear of `pending[i]` (by reply or by write-1-clear): set wins.
  - A write to `mtime` in the same cycle as an increment: the write wins and the prescaler restarts.
  - `mtimecmp` rewritten, or `enable` cleared, while in ASSERT: the presented interrupt is not withdrawn. It completes on reply.
  - `eip_reply` outside ASSERT is ignored.
  - Reset asserted mid-handshake: everything returns to reset values immediately. No pulse is replayed.

## Timing
- External path: `irq[i]` high in cycle t gives `pending[i]`=1 in t+1 and `eip`=1 in t+2, if the source is enabled and the FSM is in IDLE.
- Timer path: `mtime` reaches `mtimecmp` in cycle t gives `eip`=1, `eip_istimer`=1 in t+1.
- Reply: `eip_reply` high in cycle t gives `eip`=0, pending cleared and `claim` updated in t+1.
  - HOLDOFF occupies t+1..t+`HOLDOFF`, IDLE is at t+`HOLDOFF`+1, and the earliest re-assert is t+`HOLDOFF`+2.
- Register reads are combinational from registered state. Writes take effect at the next edge.

## Structure
- Shared package `intr_pkg` holds:
  - Register index constants `INTR_MTIME_LO` … `INTR_CLAIM`.
  - The state encoding IDLE/ASSERT/HOLDOFF.
  - `TIMER_ID`=16.
- Sub-module `intr_timer` holds the prescaler, the `mtime` and `mtimecmp` registers, their word writes, and the `timer_pend` compare.
- The arbiter, FSM, pending/enable/claim registers and read mux stay in `intr_ctrl`.

## Test plan
- Enable=4'b0001. Pulse `irq[0]` at cycle 10 → `eip`=1, `eip_istimer`=0 at cycle 12. Reply at 15 → `eip`=0 and `pending`=0 at 16, `claim`=0x80000000, `eip`=0 held through 18.
- `mtimecmp`=20, `TICK_DIV`=1, from reset → `eip`=1, `eip_istimer`=1 once `mtime`=20. Reply, then after holdoff `eip` re-asserts because the level persists. Write `mtimecmp`=all ones → no further assert.
- Enable=4'b1111, `irq[3]` and `irq[1]` in the same cycle, plus `timer_pend` → serviced in order 1, 3, timer, with `claim` id 1, 3, 16.
- `irq[2]` pulse in the same cycle as a write of 4 to `pending` → `pending[2]` reads 1.
- Write `mtime` low word = 0xFFFFFFFF → next tick `mtime`=0x1_00000000. Write `mtime` on a tick cycle → written value holds.
- Drive `rst`=0 while in ASSERT → `eip`=0 asynchronously. After release, `mtimecmp` reads all ones and `pending`=0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// timer source id, claim register layout and a priority-pick helper.
package intr_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TIME_W    = 64;
    localparam int unsigned ID_W      = 5;
    localparam int unsigned MAX_IRQ   = 16;

    localparam logic [REG_IDX_W-1:0] INTR_MTIME_LO    = 4'd0;
    localparam logic [REG_IDX_W-1:0] INTR_MTIME_HI    = 4'd1;
    localparam logic [REG_IDX_W-1:0] INTR_MTIMECMP_LO = 4'd2;
    localparam logic [REG_IDX_W-1:0] INTR_MTIMECMP_HI = 4'd3;
    localparam logic [REG_IDX_W-1:0] INTR_PENDING     = 4'd4;
    localparam logic [REG_IDX_W-1:0] INTR_ENABLE      = 4'd5;
    localparam logic [REG_IDX_W-1:0] INTR_CLAIM       = 4'd6;

    localparam logic [ID_W-1:0] TIMER_ID = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } intr_state_e;

    // Software-visible claim word: {valid, 26'b0, id}
    typedef struct packed {
        logic            valid;
        logic [25:0]     rsvd;
        logic [ID_W-1:0] id;
    } claim_t;

    // Index of the lowest set bit (0 when the vector is empty)
    function automatic logic [ID_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = int'(MAX_IRQ) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/intr_timer.sv
// Machine timer: prescaler, free-running 64-bit mtime, mtimecmp, word writes
// and the mtime >= mtimecmp level.
// Ports:
//   clk, rst            clock, async active-low reset
//   we, a, d            register write strobe, word index, data
//   mtime, mtimecmp     registered timer values
//   timer_pend_c        combinational unsigned mtime >= mtimecmp
module intr_timer
    import intr_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] a,
    input  logic [DATA_W-1:0]    d,
    output logic [TIME_W-1:0]    mtime,
    output logic [TIME_W-1:0]    mtimecmp,
    output logic                 timer_pend_c
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescale;
    logic             tick_c;
    logic             wr_time_lo_c;
    logic             wr_time_hi_c;
    logic             wr_cmp_lo_c;
    logic             wr_cmp_hi_c;
    logic             wr_time_c;

    assign wr_time_lo_c = we && (a == INTR_MTIME_LO);
    assign wr_time_hi_c = we && (a == INTR_MTIME_HI);
    assign wr_cmp_lo_c  = we && (a == INTR_MTIMECMP_LO);
    assign wr_cmp_hi_c  = we && (a == INTR_MTIMECMP_HI);
    assign wr_time_c    = wr_time_lo_c || wr_time_hi_c;
    assign tick_c       = (prescale == PRE_LAST);

    // Prescaler restarts on every tick and on any mtime write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale <= '0;
        end else if (wr_time_c || tick_c) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    // A software write to either mtime word overrides that cycle's increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr_time_c) begin
            if (wr_time_lo_c) begin
                mtime[31:0] <= d;
            end
            if (wr_time_hi_c) begin
                mtime[63:32] <= d;
            end
        end else if (tick_c) begin
            mtime <= mtime + TIME_W'(1);
        end
    end

    // Compare register, reset to the maximum so the timer starts quiet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= '1;
        end else begin
            if (wr_cmp_lo_c) begin
                mtimecmp[31:0] <= d;
            end
            if (wr_cmp_hi_c) begin
                mtimecmp[63:32] <= d;
            end
        end
    end

    assign timer_pend_c = (mtime >= mtimecmp);

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt aggregator: sticky pending bits for external pulses, enable mask,
// priority arbitration against the machine timer, and the eip/eip_reply
// handshake towards the privilege unit, with a memory-mapped register file.
// Ports:
//   clk, rst              clock, async active-low reset
//   a, d, we, spo         register index, write data, write strobe, comb read data
//   irq                   external single-cycle interrupt pulses
//   eip, eip_istimer      presented interrupt and timer flag (registered)
//   eip_reply             acknowledge pulse from the privilege unit
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned N_IRQ    = 4,
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned HOLDOFF  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] a,
    input  logic [DATA_W-1:0]    d,
    input  logic                 we,
    output logic [DATA_W-1:0]    spo,
    input  logic [N_IRQ-1:0]     irq,
    output logic                 eip,
    output logic                 eip_istimer,
    input  logic                 eip_reply
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    intr_state_e       state;
    intr_state_e       state_d;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   sel_id_d;
    logic              eip_d;
    logic              istimer_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;
    claim_t            claim;
    claim_t            claim_d;

    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  enable;
    logic [N_IRQ-1:0]  eligible_c;
    logic [N_IRQ-1:0]  reply_clr_c;
    logic [N_IRQ-1:0]  wr_clr_c;

    logic [TIME_W-1:0] mtime;
    logic [TIME_W-1:0] mtimecmp;
    logic              timer_pend_c;

    intr_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .a            (a),
        .d            (d),
        .mtime        (mtime),
        .mtimecmp     (mtimecmp),
        .timer_pend_c (timer_pend_c)
    );

    assign eligible_c = pending & enable;
    assign wr_clr_c   = (we && (a == INTR_PENDING)) ? d[N_IRQ-1:0] : '0;

    // Handshake FSM: arbitrate in idle, hold until reply, then quiet period
    always_comb begin
        state_d     = state;
        sel_id_d    = sel_id;
        eip_d       = eip;
        istimer_d   = eip_istimer;
        hold_cnt_d  = hold_cnt;
        claim_d     = claim;
        reply_clr_c = '0;
        case (state)
            ST_IDLE: begin
                if (|eligible_c) begin
                    sel_id_d  = lowest_set(MAX_IRQ'(eligible_c));
                    eip_d     = 1'b1;
                    istimer_d = 1'b0;
                    state_d   = ST_ASSERT;
                end else if (timer_pend_c) begin
                    sel_id_d  = TIMER_ID;
                    eip_d     = 1'b1;
                    istimer_d = 1'b1;
                    state_d   = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (eip_reply) begin
                    eip_d         = 1'b0;
                    istimer_d     = 1'b0;
                    claim_d.valid = 1'b1;
                    claim_d.rsvd  = '0;
                    claim_d.id    = sel_id;
                    // Timer id never matches an external line, so the level is left alone
                    for (int i = 0; i < int'(N_IRQ); i++) begin
                        if (sel_id == ID_W'(i)) begin
                            reply_clr_c[i] = 1'b1;
                        end
                    end
                    hold_cnt_d = HOLD_W'(HOLDOFF - 1);
                    state_d    = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and handshake output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            sel_id      <= '0;
            eip         <= 1'b0;
            eip_istimer <= 1'b0;
            hold_cnt    <= '0;
            claim       <= '0;
        end else begin
            state       <= state_d;
            sel_id      <= sel_id_d;
            eip         <= eip_d;
            eip_istimer <= istimer_d;
            hold_cnt    <= hold_cnt_d;
            claim       <= claim_d;
        end
    end

    // Sticky pending: a new pulse beats a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(wr_clr_c | reply_clr_c)) | irq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable <= '0;
        end else if (we && (a == INTR_ENABLE)) begin
            enable <= d[N_IRQ-1:0];
        end
    end

    // Combinational read mux over registered state
    always_comb begin
        spo = '0;
        case (a)
            INTR_MTIME_LO:    spo = mtime[31:0];
            INTR_MTIME_HI:    spo = mtime[63:32];
            INTR_MTIMECMP_LO: spo = mtimecmp[31:0];
            INTR_MTIMECMP_HI: spo = mtimecmp[63:32];
            INTR_PENDING:     spo = DATA_W'(pending);
            INTR_ENABLE:      spo = DATA_W'(enable);
            INTR_CLAIM:       spo = claim;
            default:          spo = '0;
        endcase
    end

endmodule
